// File: rtl/mp_bus_wait_ctrl.sv
// 68k bus-cycle terminator: per-region wait states, optional WAIT_b stretch,
// timeout to BERR_b, autovectored IACK, and a synchronised interrupt encoder.
module mp_bus_wait_ctrl #(
  parameter int NREG     = 4,
  parameter int WS_WIDTH = 4,
  parameter int TIMEOUT  = 64,
  parameter int NINT     = 7
) (
  input  logic                     MCKR,
  input  logic                     SYSRES,
  input  logic                     AS_b,
  input  logic [2:0]               FC,
  input  logic [NREG-1:0]          SEL,
  input  logic [NREG*WS_WIDTH-1:0] WS_CFG,
  input  logic [NREG-1:0]          EXT_WAIT_EN,
  input  logic                     WAIT_b,
  input  logic [NINT-1:0]          INT_b,
  output logic                     DTACK_b,
  output logic                     BERR_b,
  output logic                     VPA_b,
  output logic [2:0]               IPL_b,
  output logic                     BUSY,
  output logic [NREG-1:0]          ERR_SEL
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [2:0] {IDLE, COUNT, EXTW, ACK, IACK, ERR, DONE} state_t;

  state_t              state_q;
  logic [WS_WIDTH-1:0] wcnt_q;
  logic [TW-1:0]       tcnt_q;
  logic [RW-1:0]       region_q;
  logic                region_ok_q;
  logic                dtack_b_q;
  logic                berr_b_q;
  logic                vpa_b_q;
  logic                busy_q;
  logic [NREG-1:0]     err_sel_q;

  logic [WS_WIDTH-1:0] ws_arr [NREG];
  logic [RW-1:0]       sel_idx;
  logic                timeout_hit;
  logic [TW-1:0]       tcnt_d;

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_ws
      assign ws_arr[gi] = WS_CFG[gi*WS_WIDTH +: WS_WIDTH];
    end
  endgenerate

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NREG; i++) begin
      if (SEL[i]) sel_idx = RW'(i);
    end
  end

  // tcnt saturates at TIMEOUT so a stalled cycle cannot wrap past the limit
  assign timeout_hit = (tcnt_q == TW'(TIMEOUT));
  assign tcnt_d      = timeout_hit ? tcnt_q : tcnt_q + TW'(1);

  always_ff @(posedge MCKR or posedge SYSRES) begin
    if (SYSRES) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      tcnt_q      <= '0;
      region_q    <= '0;
      region_ok_q <= 1'b0;
      dtack_b_q   <= 1'b1;
      berr_b_q    <= 1'b1;
      vpa_b_q     <= 1'b1;
      busy_q      <= 1'b0;
      err_sel_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!AS_b) begin
            busy_q <= 1'b1;
            tcnt_q <= TW'(1);
            if (FC == 3'b111) begin
              state_q <= IACK;
            end else if ($onehot(SEL)) begin
              state_q     <= COUNT;
              region_q    <= sel_idx;
              region_ok_q <= 1'b1;
              wcnt_q      <= ws_arr[sel_idx];
            end else if (SEL == '0) begin
              state_q     <= COUNT;
              region_ok_q <= 1'b0;
              wcnt_q      <= '0;
            end else begin
              state_q   <= ERR;
              err_sel_q <= SEL;
            end
          end
        end
        COUNT: begin
          if (AS_b) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            tcnt_q <= tcnt_d;
            // acknowledge takes priority over a coincident timeout
            if (region_ok_q && wcnt_q == '0) begin
              state_q <= EXT_WAIT_EN[region_q] ? EXTW : ACK;
            end else if (timeout_hit) begin
              state_q   <= ERR;
              err_sel_q <= SEL;
            end else if (wcnt_q != '0) begin
              wcnt_q <= wcnt_q - WS_WIDTH'(1);
            end
          end
        end
        EXTW: begin
          if (AS_b) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            tcnt_q <= tcnt_d;
            if (WAIT_b) begin
              state_q <= ACK;
            end else if (timeout_hit) begin
              state_q   <= ERR;
              err_sel_q <= SEL;
            end
          end
        end
        ACK: begin
          if (AS_b) begin
            state_q   <= DONE;
            dtack_b_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            dtack_b_q <= 1'b0;
          end
        end
        IACK: begin
          if (AS_b) begin
            state_q <= DONE;
            vpa_b_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            vpa_b_q <= 1'b0;
          end
        end
        ERR: begin
          if (AS_b) begin
            state_q  <= DONE;
            berr_b_q <= 1'b1;
            busy_q   <= 1'b0;
          end else begin
            berr_b_q <= 1'b0;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  logic [NINT-1:0] int_s1_q;
  logic [NINT-1:0] int_s2_q;
  logic [2:0]      ipl_b_q;
  logic [2:0]      level_d;

  always_comb begin
    level_d = 3'd0;
    for (int i = 0; i < NINT; i++) begin
      if (!int_s2_q[i]) level_d = 3'(i + 1);
    end
  end

  always_ff @(posedge MCKR or posedge SYSRES) begin
    if (SYSRES) begin
      int_s1_q <= '1;
      int_s2_q <= '1;
      ipl_b_q  <= 3'b111;
    end else begin
      int_s1_q <= INT_b;
      int_s2_q <= int_s1_q;
      ipl_b_q  <= ~level_d;
    end
  end

  assign DTACK_b = dtack_b_q;
  assign BERR_b  = berr_b_q;
  assign VPA_b   = vpa_b_q;
  assign BUSY    = busy_q;
  assign ERR_SEL = err_sel_q;
  assign IPL_b   = ipl_b_q;

endmodule

// File: tb/tb_mp_bus_wait_ctrl.sv
// Randomised bench for mp_bus_wait_ctrl; expected strobe timing is derived per
// transaction from the cycle-termination rules, then checked edge by edge.
module tb_mp_bus_wait_ctrl;

  localparam int NREG = 4;
  localparam int WSW  = 4;
  localparam int TOUT = 64;
  localparam int NINT = 7;

  logic            MCKR;
  logic            SYSRES;
  logic            AS_b;
  logic [2:0]      FC;
  logic [NREG-1:0] SEL;
  logic [NREG*WSW-1:0] WS_CFG;
  logic [NREG-1:0] EXT_WAIT_EN;
  logic            WAIT_b;
  logic [NINT-1:0] INT_b;
  logic            DTACK_b;
  logic            BERR_b;
  logic            VPA_b;
  logic [2:0]      IPL_b;
  logic            BUSY;
  logic [NREG-1:0] ERR_SEL;

  int n_checks = 0;
  int n_errors = 0;
  int ws_tab  [NREG];
  bit ext_tab [NREG];

  mp_bus_wait_ctrl #(.NREG(NREG), .WS_WIDTH(WSW), .TIMEOUT(TOUT), .NINT(NINT)) dut (
    .MCKR(MCKR), .SYSRES(SYSRES), .AS_b(AS_b), .FC(FC), .SEL(SEL),
    .WS_CFG(WS_CFG), .EXT_WAIT_EN(EXT_WAIT_EN), .WAIT_b(WAIT_b), .INT_b(INT_b),
    .DTACK_b(DTACK_b), .BERR_b(BERR_b), .VPA_b(VPA_b), .IPL_b(IPL_b),
    .BUSY(BUSY), .ERR_SEL(ERR_SEL)
  );

  initial MCKR = 1'b0;
  always #5 MCKR = ~MCKR;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply_cfg();
    for (int r = 0; r < NREG; r++) begin
      WS_CFG[r*WSW +: WSW] = ws_tab[r][WSW-1:0];
      EXT_WAIT_EN[r]       = ext_tab[r];
    end
  endtask

  function automatic logic [2:0] ipl_of(input logic [NINT-1:0] v);
    int lvl = 0;
    for (int i = 0; i < NINT; i++) if (v[i] == 1'b0) lvl = i + 1;
    return ~3'(lvl);
  endfunction

  // kind: 0=DTACK, 1=BERR, 2=VPA
  task automatic run_txn(input logic [NREG-1:0] sel, input logic [2:0] fc,
                         input int w_rel, input bit abort, input string name);
    int kind, t_str, hold, r, ack_entry;
    bit no_strobe;
    kind = 0; t_str = 0; r = 0; no_strobe = 0;
    if (fc == 3'b111) begin
      kind = 2; t_str = 1;
    end else if (sel == '0) begin
      kind = 1; t_str = TOUT + 1;
    end else if ($countones(sel) > 1) begin
      kind = 1; t_str = 1;
    end else begin
      for (int i = 0; i < NREG; i++) if (sel[i]) r = i;
      if (ext_tab[r]) ack_entry = (2 + ws_tab[r] > w_rel) ? 2 + ws_tab[r] : w_rel;
      else            ack_entry = 1 + ws_tab[r];
      if (ack_entry > TOUT) begin kind = 1; t_str = TOUT + 1; end
      else begin kind = 0; t_str = ack_entry + 1; end
    end
    if (abort && t_str > 1) begin
      hold = $urandom_range(1, t_str - 1);
      no_strobe = 1;
    end else begin
      hold = t_str + $urandom_range(0, 3);
    end
    $display("txn %s: sel=%b fc=%0d kind=%0d strobe_edge=%0d hold=%0d abort=%0d",
             name, sel, fc, kind, t_str, hold, no_strobe);
    SEL = sel; FC = fc;
    for (int k = 0; k <= hold + 1; k++) begin
      AS_b   = (k < hold) ? 1'b0 : 1'b1;
      WAIT_b = (k >= w_rel);
      @(posedge MCKR); #1;
      begin
        bit on;
        on = !no_strobe && (k >= t_str) && (k < hold);
        chk({name, ".dtack"}, 32'(DTACK_b), 32'(!(on && kind == 0)));
        chk({name, ".berr"},  32'(BERR_b),  32'(!(on && kind == 1)));
        chk({name, ".vpa"},   32'(VPA_b),   32'(!(on && kind == 2)));
        chk({name, ".busy"},  32'(BUSY),    32'(k < hold));
      end
    end
    if (kind == 1 && !no_strobe) chk({name, ".err_sel"}, 32'(ERR_SEL), 32'(sel));
    SEL = '0; FC = 3'd0; WAIT_b = 1'b1;
  endtask

  initial begin
    SYSRES = 1'b1; AS_b = 1'b1; FC = 3'd0; SEL = '0; WAIT_b = 1'b1;
    INT_b = '1; WS_CFG = '0; EXT_WAIT_EN = '0;
    for (int r = 0; r < NREG; r++) begin ws_tab[r] = $urandom_range(0, 15); ext_tab[r] = 1'b0; end
    ws_tab[1] = 3; ext_tab[1] = 0;
    ws_tab[2] = 0; ext_tab[2] = 1;
    apply_cfg();
    #3;
    chk("rst.dtack", 32'(DTACK_b), 32'd1);
    chk("rst.berr",  32'(BERR_b),  32'd1);
    chk("rst.vpa",   32'(VPA_b),   32'd1);
    chk("rst.ipl",   32'(IPL_b),   32'd7);
    chk("rst.busy",  32'(BUSY),    32'd0);
    chk("rst.errsel", 32'(ERR_SEL), 32'd0);
    #10 SYSRES = 1'b0;
    @(posedge MCKR); #1;

    run_txn(4'b0010, 3'd1, 0,   0, "ws3");
    run_txn(4'b0100, 3'd2, 6,   0, "extw6");
    run_txn(4'b0000, 3'd5, 0,   0, "nosel_timeout");
    run_txn(4'b0110, 3'd1, 0,   0, "multihot");
    run_txn(4'b0000, 3'b111, 0, 0, "iack");
    run_txn(4'b0010, 3'd1, 0,   1, "abort_count");
    run_txn(4'b0100, 3'd2, 64,  0, "ack_at_timeout");
    run_txn(4'b0100, 3'd2, 65,  0, "ext_timeout");

    for (int n = 0; n < 30; n++) begin
      int kind;
      logic [NREG-1:0] s;
      if (n % 8 == 0) begin
        for (int r = 0; r < NREG; r++) begin
          ws_tab[r]  = $urandom_range(0, 15);
          ext_tab[r] = $urandom_range(0, 1);
        end
        apply_cfg();
      end
      kind = $urandom_range(0, 4);
      case (kind)
        0: run_txn(4'b0001 << $urandom_range(0, 3), 3'($urandom_range(0, 6)),
                   $urandom_range(0, 12), 0, "rnd_onehot");
        1: run_txn(4'b0001 << $urandom_range(0, 3), 3'($urandom_range(0, 6)),
                   $urandom_range(0, 12), 1, "rnd_abort");
        2: begin
          s = '0;
          while ($countones(s) < 2) s = 4'($urandom_range(0, 15));
          run_txn(s, 3'($urandom_range(0, 6)), 0, 0, "rnd_multihot");
        end
        3: run_txn(4'($urandom_range(0, 15)), 3'b111, 0, 0, "rnd_iack");
        default: run_txn(4'b0000, 3'($urandom_range(0, 6)), 0, $urandom_range(0, 1), "rnd_nosel");
      endcase
    end

    // asynchronous reset while DTACK_b is asserted
    ws_tab[0] = 0; ext_tab[0] = 0; apply_cfg();
    $display("txn reset_in_ack: sel=0001 ws=0");
    SEL = 4'b0001; AS_b = 1'b0;
    for (int k = 0; k <= 2; k++) begin
      @(posedge MCKR); #1;
    end
    chk("rstack.dtack_before", 32'(DTACK_b), 32'd0);
    #1 SYSRES = 1'b1;
    #1;
    chk("rstack.dtack", 32'(DTACK_b), 32'd1);
    chk("rstack.busy",  32'(BUSY),    32'd0);
    chk("rstack.berr",  32'(BERR_b),  32'd1);
    AS_b = 1'b1; SEL = '0;
    #1 SYSRES = 1'b0;
    @(posedge MCKR); #1;
    chk("rstack.idle_busy",  32'(BUSY),    32'd0);
    chk("rstack.idle_dtack", 32'(DTACK_b), 32'd1);
    run_txn(4'b0001, 3'd1, 0, 0, "post_reset");

    // interrupt encoder: new level appears after the third edge
    for (int n = 0; n < 16; n++) begin
      logic [NINT-1:0] v;
      logic [2:0] prev;
      prev = ipl_of(INT_b);
      if (n == 0)      v = 7'b1111010;
      else if (n == 1) v = '1;
      else             v = 7'($urandom);
      $display("txn int: INT_b=%b expected IPL_b=%b", v, ipl_of(v));
      INT_b = v;
      for (int e = 1; e <= 4; e++) begin
        @(posedge MCKR); #1;
        chk("ipl", 32'(IPL_b), 32'((e >= 3) ? ipl_of(v) : prev));
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
